water_flow_controller: RTL and testbench



---
 rtl/wf_pkg.sv | 24 ++
 rtl/flow_progress_monitor.sv | 76 +++++++
 rtl/water_flow_controller.sv | 140 ++++++++++++++
 tb/tb_water_flow_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wf_pkg.sv
// Shared types and default tuning for the water flow controller.
package wf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILLING,
    DRAINING,
    SETTLE,
    DONE,
    ERROR
  } state_t;

  localparam logic MODE_FILL  = 1'b0;
  localparam logic MODE_DRAIN = 1'b1;

  localparam int DEF_LEVEL_W       = 10;
  localparam int DEF_MAX_LEVEL     = 900;
  localparam int DEF_EMPTY_LEVEL   = 0;
  localparam int DEF_CHECK_CYCLES  = 16;
  localparam int DEF_MIN_DELTA     = 5;
  localparam int DEF_MAX_STALLS    = 4;
  localparam int DEF_SETTLE_CYCLES = 3;

endpackage

// File: rtl/flow_progress_monitor.sv
// Watches the level sensor over fixed windows and reports when too many
// consecutive windows showed too little movement in the active direction.
module flow_progress_monitor
  import wf_pkg::*;
#(
  parameter int LEVEL_W      = DEF_LEVEL_W,
  parameter int CHECK_CYCLES = DEF_CHECK_CYCLES,
  parameter int MIN_DELTA    = DEF_MIN_DELTA,
  parameter int MAX_STALLS   = DEF_MAX_STALLS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               freeze,
  input  logic               restart,
  input  logic               dir,
  input  logic [LEVEL_W-1:0] sensor,
  output logic               stall_error
);

  localparam int WIN_W   = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;
  localparam int STALL_W = $clog2(MAX_STALLS + 1);

  logic [WIN_W-1:0]   win_cnt;
  logic [LEVEL_W-1:0] ref_level;
  logic [LEVEL_W-1:0] delta;
  logic [STALL_W-1:0] stall_cnt;
  logic               at_tc;
  logic               low;

  // Progress since the window start, clipped at zero when moving the wrong way.
  always_comb begin
    at_tc = (win_cnt == WIN_W'(CHECK_CYCLES - 1));
    delta = '0;
    if (dir == MODE_DRAIN) begin
      if (ref_level > sensor) delta = ref_level - sensor;
    end else begin
      if (sensor > ref_level) delta = sensor - ref_level;
    end
    low = (delta < LEVEL_W'(MIN_DELTA));
    // Flags on the very edge the last allowed stall is counted.
    stall_error = enable && !freeze && at_tc && low &&
                  (stall_cnt >= STALL_W'(MAX_STALLS - 1));
  end

  // Window/ref/stall bookkeeping; outside active phases ref simply tracks the
  // sensor so that re-entering an active phase starts from the current level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt   <= '0;
      ref_level <= '0;
      stall_cnt <= '0;
    end else if (restart) begin
      win_cnt   <= '0;
      ref_level <= sensor;
      stall_cnt <= '0;
    end else if (freeze) begin
      win_cnt   <= win_cnt;
    end else if (enable) begin
      if (at_tc) begin
        win_cnt   <= '0;
        ref_level <= sensor;
        if (!low)
          stall_cnt <= '0;
        else if (stall_cnt != STALL_W'(MAX_STALLS))
          stall_cnt <= stall_cnt + 1'b1;
      end else begin
        win_cnt <= win_cnt + 1'b1;
      end
    end else begin
      win_cnt   <= '0;
      ref_level <= sensor;
    end
  end

endmodule

// File: rtl/water_flow_controller.sv
// Fill/drain sequencer: drives valve and pump, confirms the level with a
// settle window and latches an error when the level stops moving.
module water_flow_controller
  import wf_pkg::*;
#(
  parameter int LEVEL_W       = DEF_LEVEL_W,
  parameter int MAX_LEVEL     = DEF_MAX_LEVEL,
  parameter int EMPTY_LEVEL   = DEF_EMPTY_LEVEL,
  parameter int CHECK_CYCLES  = DEF_CHECK_CYCLES,
  parameter int MIN_DELTA     = DEF_MIN_DELTA,
  parameter int MAX_STALLS    = DEF_MAX_STALLS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               water_flow_reset,
  input  logic               water_flow_mode,
  input  logic               flow_start,
  input  logic               pause,
  input  logic [LEVEL_W-1:0] water_level_sensor,
  input  logic [LEVEL_W-1:0] water_level,
  output logic               water_valve,
  output logic               drain_pump,
  output logic               busy,
  output logic               flow_done,
  output logic               water_flow_error
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  state_t             state, state_n;
  logic               mode_q, mode_n;
  logic [LEVEL_W-1:0] target_q, target_n, clamped;
  logic [SET_W-1:0]   settle_cnt, settle_n;
  logic               goal, goal_start, start_ok, busy_state, stall_error;

  // Completion tests: against latched settings, and against the settings
  // being presented with a start request.
  always_comb begin
    clamped    = (water_level > LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : water_level;
    goal_start = (water_flow_mode == MODE_DRAIN) ?
                 (water_level_sensor <= LEVEL_W'(EMPTY_LEVEL)) :
                 (water_level_sensor >= clamped);
    goal       = (mode_q == MODE_DRAIN) ?
                 (water_level_sensor <= LEVEL_W'(EMPTY_LEVEL)) :
                 (water_level_sensor >= target_q);
    busy_state = (state == FILLING) || (state == DRAINING) || (state == SETTLE);
  end

  // Next-state and latch updates; abort beats start, start beats pause.
  always_comb begin
    state_n  = state;
    mode_n   = mode_q;
    target_n = target_q;
    settle_n = settle_cnt;
    start_ok = 1'b0;
    if (water_flow_reset) begin
      state_n  = IDLE;
      settle_n = '0;
    end else if ((state == IDLE || state == DONE) && flow_start) begin
      start_ok = 1'b1;
      mode_n   = water_flow_mode;
      target_n = clamped;
      settle_n = '0;
      if (goal_start)                       state_n = SETTLE;
      else if (water_flow_mode == MODE_DRAIN) state_n = DRAINING;
      else                                  state_n = FILLING;
    end else if (!(pause && busy_state)) begin
      case (state)
        FILLING, DRAINING: begin
          if (goal) begin
            state_n  = SETTLE;
            settle_n = '0;
          end else if (stall_error) begin
            state_n = ERROR;
          end
        end
        SETTLE: begin
          if (goal) begin
            if (settle_cnt >= SET_W'(SETTLE_CYCLES - 1)) state_n = DONE;
            else settle_n = settle_cnt + 1'b1;
          end else begin
            state_n  = (mode_q == MODE_DRAIN) ? DRAINING : FILLING;
            settle_n = '0;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // State, latched settings and settle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mode_q     <= MODE_FILL;
      target_q   <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_n;
      mode_q     <= mode_n;
      target_q   <= target_n;
      settle_cnt <= settle_n;
    end
  end

  // Registered outputs decoded from the upcoming state and pause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      water_valve      <= 1'b0;
      drain_pump       <= 1'b0;
      busy             <= 1'b0;
      flow_done        <= 1'b0;
      water_flow_error <= 1'b0;
    end else begin
      water_valve      <= (state_n == FILLING) && !pause;
      drain_pump       <= (state_n == DRAINING) && !pause;
      busy             <= (state_n == FILLING) || (state_n == DRAINING) || (state_n == SETTLE);
      flow_done        <= (state_n == DONE);
      water_flow_error <= (state_n == ERROR);
    end
  end

  flow_progress_monitor #(
    .LEVEL_W      (LEVEL_W),
    .CHECK_CYCLES (CHECK_CYCLES),
    .MIN_DELTA    (MIN_DELTA),
    .MAX_STALLS   (MAX_STALLS)
  ) u_monitor (
    .clk         (clk),
    .rst         (reset),
    .enable      ((state == FILLING) || (state == DRAINING)),
    .freeze      (pause),
    .restart     (start_ok || water_flow_reset),
    .dir         (mode_q),
    .sensor      (water_level_sensor),
    .stall_error (stall_error)
  );

endmodule

// File: tb/tb_water_flow_controller.sv
// Scoreboard bench: a phase-level model predicts outputs on each rising edge,
// a monitor compares them against the DUT on the falling edge.
module tb_water_flow_controller;

  localparam int LW = 10, MAXL = 900, EMPTY = 0, CC = 8, MD = 4, MS = 3, SC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wfr = 1'b0, mode = 1'b0, start = 1'b0, pause = 1'b0;
  logic [LW-1:0] sensor = '0, level = '0;
  logic          valve, pump, busy, done, err;

  water_flow_controller #(
    .LEVEL_W(LW), .MAX_LEVEL(MAXL), .EMPTY_LEVEL(EMPTY), .CHECK_CYCLES(CC),
    .MIN_DELTA(MD), .MAX_STALLS(MS), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .water_flow_reset(wfr), .water_flow_mode(mode),
    .flow_start(start), .pause(pause), .water_level_sensor(sensor),
    .water_level(level), .water_valve(valve), .drain_pump(pump), .busy(busy),
    .flow_done(done), .water_flow_error(err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [4:0] q[$];

  // Reference model state: phase name plus plain integer bookkeeping.
  string phase = "idle";
  bit    m_drain = 0;
  int    m_target = 0, m_ref = 0, m_win = 0, m_stalls = 0, m_held = 0;

  function automatic bit goal_met(int s);
    if (m_drain) return s <= EMPTY;
    return s >= m_target;
  endfunction

  function automatic bit active();
    return phase == "fill" || phase == "drain" || phase == "settle";
  endfunction

  task automatic model_step();
    int s, gain;
    bit fail_now;
    s = int'(sensor);
    fail_now = 0;
    if (wfr) begin
      phase = "idle";
    end else if ((phase == "idle" || phase == "done") && start) begin
      m_drain  = mode;
      m_target = (int'(level) > MAXL) ? MAXL : int'(level);
      m_ref = s; m_win = 0; m_stalls = 0; m_held = 0;
      if (goal_met(s))  phase = "settle";
      else if (m_drain) phase = "drain";
      else              phase = "fill";
    end else if (pause && active()) begin
      m_held = m_held;
    end else if (phase == "fill" || phase == "drain") begin
      m_win++;
      if (m_win == CC) begin
        gain = m_drain ? (m_ref - s) : (s - m_ref);
        if (gain < MD) m_stalls++;
        else           m_stalls = 0;
        m_ref = s;
        m_win = 0;
        fail_now = (m_stalls >= MS);
      end
      if (goal_met(s)) begin
        phase  = "settle";
        m_held = 0;
      end else if (fail_now) begin
        phase = "error";
      end
    end else if (phase == "settle") begin
      if (goal_met(s)) begin
        m_held++;
        if (m_held >= SC) phase = "done";
      end else begin
        if (m_drain) phase = "drain";
        else         phase = "fill";
        m_held = 0; m_win = 0; m_ref = s;
      end
    end
  endtask

  function automatic logic [4:0] expected();
    logic [4:0] e;
    e[4] = (phase == "fill") && !pause;
    e[3] = (phase == "drain") && !pause;
    e[2] = active();
    e[1] = (phase == "done");
    e[0] = (phase == "error");
    return e;
  endfunction

  // Model: advance on each rising edge and queue the predicted outputs.
  always @(posedge clk) begin
    if (reset) phase = "idle";
    else       model_step();
    q.push_back(expected());
  end

  // Monitor: compare DUT outputs against the scoreboard on the falling edge.
  logic [4:0] mon_exp, mon_act;
  always @(negedge clk) begin
    mon_act = {valve, pump, busy, done, err};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty @%0t: got %b, nothing expected", $time, mon_act);
    end else begin
      mon_exp = q.pop_front();
      if (reset) mon_exp = '0;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL outputs @%0t phase=%s: got valve/pump/busy/done/err=%b expected %b",
                 $time, phase, mon_act, mon_exp);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(bit md, int lvl, int s);
    mode = md; level = LW'(lvl); sensor = LW'(s); start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic async_reset_check(string name);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({valve, pump, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL %s: got %b expected 00000", name, {valve, pump, busy, done, err});
    end
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  int d, s;

  initial begin
    // 1. reset with random inputs, then a fill start
    mode = 1'($urandom); start = 1'($urandom); pause = 1'($urandom);
    wfr = 1'($urandom); sensor = LW'($urandom); level = LW'($urandom);
    cyc(3);
    reset = 1'b0; start = 0; pause = 0; wfr = 0;
    cyc(1);
    go(0, 500, 0);
    cyc(3);
    async_reset_check("async_reset_fill");

    // 2. normal fill to 300, then clamped fill to 900
    go(0, 300, 0);
    for (int i = 1; i <= 36; i++) begin sensor = LW'(i * 10); cyc(1); end
    go(0, 1000, 0);
    for (int i = 1; i <= 95; i++) begin sensor = LW'(i * 10); cyc(1); end

    // 3. fill transient
    go(0, 250, 110);
    cyc(4);
    sensor = 300; cyc(1);
    sensor = 180; cyc(3);
    sensor = 300; cyc(4);

    // 4. stall -> error, start ignored, abort clears; abort beats start
    go(0, 500, 110);
    cyc(30);
    go(1, 0, 110);
    cyc(2);
    wfr = 1; cyc(1); wfr = 0; cyc(2);
    go(0, 500, 110);
    cyc(3);
    wfr = 1; start = 1; cyc(1); wfr = 0; start = 0; cyc(2);

    // 5. drain with a 20-cycle pause
    go(1, 0, 650);
    for (int i = 1; i <= 68; i++) begin
      if (i == 30) begin pause = 1; cyc(20); pause = 0; end
      s = 650 - i * 10;
      sensor = LW'((s < 0) ? 0 : s);
      cyc(1);
    end

    // 6. drain start already empty; start while busy; reset mid-fill
    go(1, 0, 0);
    cyc(4);
    go(0, 400, 0);
    for (int i = 1; i <= 5; i++) begin sensor = LW'(i * 10); cyc(1); end
    mode = 1; level = 50; start = 1; cyc(1); start = 0;
    for (int i = 6; i <= 12; i++) begin sensor = LW'(i * 10); cyc(1); end
    async_reset_check("async_reset_midfill");

    // random traffic, sensor biased by the model's phase
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 9) == 0);
      pause = ($urandom_range(0, 7) == 0);
      wfr   = ($urandom_range(0, 59) == 0);
      mode  = 1'($urandom_range(0, 1));
      level = LW'($urandom_range(0, 1023));
      d = int'($urandom_range(0, 12)) - 6;
      if (phase == "fill")  d += 6;
      if (phase == "drain") d -= 6;
      s = int'(sensor) + d;
      if ($urandom_range(0, 99) == 0) s = 0;
      sensor = LW'((s < 0) ? 0 : (s > 1023) ? 1023 : s);
      cyc(1);
    end
    start = 0; pause = 0; wfr = 0;
    cyc(3);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
